// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the program-memory, PC-unit and ALU-facing signals of the fetch
//   sequencer.
//   master : the sequencer (drives memory request, PC control, ALU strobe, status)
//   slave  : the surrounding datapath (drives run, pc, memory data, ALU zero flag)
//   Signals:
//     run          level: execute (1) / stop at next instruction boundary (0)
//     pc           current PC from the PC unit
//     mem_rdata    program memory read data
//     mem_ready    read data valid this cycle
//     alu_zero     zero flag of the last ALU result
//     mem_addr     program memory address (pc while reading, else 0)
//     mem_rd       read request
//     pc_en        one-cycle strobe: PC unit applies pc_mode
//     pc_mode      00 inc, 01 dec, 10 load jump_target, 11 load ALU result
//     jump_target  registered operand byte (PC load data)
//     ir           instruction register
//     alu_go       one-cycle ALU start strobe
//     halted       HLT executed
//     fault        memory timeout occurred
// ----------------------------------------------------------------------------
interface fetch_sequencer_if;
    logic       run;
    logic [7:0] pc;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       alu_zero;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       pc_en;
    logic [1:0] pc_mode;
    logic [7:0] jump_target;
    logic [7:0] ir;
    logic       alu_go;
    logic       halted;
    logic       fault;

    modport master (
        input  run, pc, mem_rdata, mem_ready, alu_zero,
        output mem_addr, mem_rd, pc_en, pc_mode, jump_target, ir,
               alu_go, halted, fault
    );

    modport slave (
        output run, pc, mem_rdata, mem_ready, alu_zero,
        input  mem_addr, mem_rd, pc_en, pc_mode, jump_target, ir,
               alu_go, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Fetch/decode control stage of the calculator datapath. Reads the byte at
//   the current PC, decodes ir[7:4] and steers the PC unit (pc_en/pc_mode) and
//   the ALU (alu_go). JMP/JZ fetch a second operand byte into jump_target.
//   Ports:
//     clk   rising-edge clock
//     clr   synchronous active-high reset
//     bus   fetch_sequencer_if.master (memory, PC unit, ALU, status signals)
//   Parameter:
//     WAIT_MAX  consecutive non-ready read cycles tolerated before FAULT (1..255)
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               clr,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, FETCH2, EXEC, HALT, FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] jt_q, jt_d;
    logic [7:0] wait_q, wait_d;

    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       pc_en;
    logic [1:0] pc_mode;
    logic       alu_go;
    logic       halted;
    logic       fault;
    logic       show_regs;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ir_q    <= 8'h00;
            jt_q    <= 8'h00;
            wait_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            jt_q    <= jt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        jt_d      = jt_q;
        wait_d    = wait_q;
        mem_rd    = 1'b0;
        mem_addr  = 8'h00;
        pc_en     = 1'b0;
        pc_mode   = 2'b00;
        alu_go    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        show_regs = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.run) state_d = FETCH;
            end

            // Opcode and operand reads share one handshake and timeout;
            // a ready in the last allowed cycle still wins over the fault.
            FETCH, FETCH2: begin
                show_regs = 1'b1;
                mem_rd    = 1'b1;
                mem_addr  = bus.pc;
                if (bus.mem_ready) begin
                    wait_d = 8'h00;
                    if (state_q == FETCH) begin
                        ir_d    = bus.mem_rdata;
                        state_d = DECODE;
                    end else begin
                        jt_d    = bus.mem_rdata;
                        state_d = EXEC;
                    end
                end else if (wait_q >= WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_d = sat_inc(wait_q);
                end
            end

            DECODE: begin
                show_regs = 1'b1;
                pc_en     = 1'b1;
                state_d   = bus.run ? FETCH : IDLE;
                case (ir_q[7:4])
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: alu_go = 1'b1;
                    // Step the PC onto the operand byte before reading it.
                    4'h8, 4'h9: state_d = FETCH2;
                    4'hA: pc_mode = 2'b11;
                    4'hB: pc_mode = 2'b01;
                    4'hF: begin
                        pc_en   = 1'b0;
                        state_d = HALT;
                    end
                    default: ;
                endcase
            end

            // Untaken JZ increments past the operand byte instead of loading.
            EXEC: begin
                show_regs = 1'b1;
                pc_en     = 1'b1;
                pc_mode   = (ir_q[7:4] == 4'h9 && !bus.alu_zero) ? 2'b00 : 2'b10;
                state_d   = bus.run ? FETCH : IDLE;
            end

            HALT:  halted = 1'b1;
            FAULT: fault  = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_rd      = mem_rd;
    assign bus.mem_addr    = mem_addr;
    assign bus.pc_en       = pc_en;
    assign bus.pc_mode     = pc_mode;
    assign bus.alu_go      = alu_go;
    assign bus.halted      = halted;
    assign bus.fault       = fault;
    // Idle, halted and faulted states present all-zero outputs.
    assign bus.ir          = show_regs ? ir_q : 8'h00;
    assign bus.jump_target = show_regs ? jt_q : 8'h00;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.WAIT_MAX(15)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem [256];
    int         ready_mode;      // 0 never, 1 always, 2 random
    int         streak;
    logic [7:0] alu_res;
    logic [7:0] fetch_q [$];
    int         alu_go_seen;
    logic       pc_en_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_rd"}, bus.mem_rd, 0);
        chk({tag, " mem_addr"}, bus.mem_addr, 0);
        chk({tag, " pc_en"}, bus.pc_en, 0);
        chk({tag, " pc_mode"}, bus.pc_mode, 0);
        chk({tag, " alu_go"}, bus.alu_go, 0);
        chk({tag, " halted"}, bus.halted, 0);
        chk({tag, " fault"}, bus.fault, 0);
        chk({tag, " ir"}, bus.ir, 0);
        chk({tag, " jump_target"}, bus.jump_target, 0);
    endtask

    // One clock: behaves as PC unit + program memory around the DUT.
    task automatic tick();
        logic [7:0] npc;
        npc = bus.pc;
        if (bus.pc_en === 1'b1) begin
            case (bus.pc_mode)
                2'b00:   npc = bus.pc + 8'd1;
                2'b01:   npc = bus.pc - 8'd1;
                2'b10:   npc = bus.jump_target;
                default: npc = alu_res;
            endcase
        end
        chk("pc_en_pair", {31'd0, bus.pc_en & pc_en_prev}, 0);
        pc_en_prev = bus.pc_en;
        if (bus.mem_rd === 1'b1) begin
            chk("mem_addr_is_pc", bus.mem_addr, bus.pc);
            if (bus.mem_ready) fetch_q.push_back(bus.mem_addr);
        end
        if (bus.alu_go === 1'b1) alu_go_seen++;
        @(posedge clk);
        #1;
        bus.pc        = npc;
        bus.mem_rdata = mem[npc];
        case (ready_mode)
            0: bus.mem_ready = 1'b0;
            1: bus.mem_ready = 1'b1;
            default: begin
                bus.mem_ready = (streak >= 4) || ($urandom_range(0, 2) != 0);
                streak = bus.mem_ready ? 0 : streak + 1;
            end
        endcase
        #1;
    endtask

    // Start one instruction from IDLE at addr; leaves the DUT in FETCH.
    task automatic start_at(input logic [7:0] addr);
        bus.pc = addr;
        bus.mem_rdata = mem[addr];
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("start mem_rd", bus.mem_rd, 1);
        chk("start mem_addr", bus.mem_addr, addr);
    endtask

    task automatic single(input logic [7:0] addr, input logic [7:0] op,
                          input logic exp_en, input logic [1:0] exp_mode,
                          input logic exp_alu);
        mem[addr] = op;
        start_at(addr);
        tick();
        chk("dec ir", bus.ir, op);
        chk("dec pc_en", bus.pc_en, exp_en);
        if (exp_en) chk("dec pc_mode", bus.pc_mode, exp_mode);
        chk("dec alu_go", bus.alu_go, exp_alu);
    endtask

    task automatic branch(input logic [7:0] addr, input logic [7:0] op,
                          input logic [7:0] tgt, input logic zero,
                          input logic [1:0] exp_mode, input logic [7:0] exp_pc);
        mem[addr] = op;
        mem[addr + 8'd1] = tgt;
        bus.alu_zero = zero;
        start_at(addr);
        tick();
        chk("br dec pc_en", bus.pc_en, 1);
        chk("br dec pc_mode", bus.pc_mode, 0);
        tick();
        chk("br fetch2 mem_rd", bus.mem_rd, 1);
        chk("br fetch2 addr", bus.mem_addr, addr + 8'd1);
        chk("br fetch2 pc_en", bus.pc_en, 0);
        tick();
        chk("br exec pc_en", bus.pc_en, 1);
        chk("br exec pc_mode", bus.pc_mode, exp_mode);
        chk("br exec target", bus.jump_target, tgt);
        tick();
        chk("br next pc", bus.pc, exp_pc);
        chk("br idle mem_rd", bus.mem_rd, 0);
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] p;
        logic [7:0] op;
        logic       z;
        logic       exp_halt;
        int         exp_alu;
        int         cycles;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ready_mode    = 1;
        streak        = 0;
        alu_res       = 8'hC3;
        pc_en_prev    = 1'b0;
        alu_go_seen   = 0;
        clr           = 1'b1;
        bus.run       = 1'b1;
        bus.pc        = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.mem_ready = 1'b1;
        bus.alu_zero  = 1'b0;

        // T1: reset held with run=1
        tick();
        tick();
        chk_quiet("T1 reset");

        // T2: ALU op 35 at pc 10
        bus.pc = 8'h10;
        mem[8'h10] = 8'h35;
        bus.mem_rdata = 8'h35;
        clr = 1'b0;
        tick();
        chk("T2 mem_rd", bus.mem_rd, 1);
        chk("T2 mem_addr", bus.mem_addr, 8'h10);
        bus.run = 1'b0;
        tick();
        chk("T2 ir", bus.ir, 8'h35);
        chk("T2 alu_go", bus.alu_go, 1);
        chk("T2 pc_en", bus.pc_en, 1);
        chk("T2 pc_mode", bus.pc_mode, 0);
        tick();
        chk_quiet("T2 stop");
        chk("T2 pc", bus.pc, 8'h11);

        // T3: JMP 42
        branch(8'h20, 8'h80, 8'h42, 1'b0, 2'b10, 8'h42);
        // T4: JZ not taken / taken, JR, BACK, NOP-class, HLT-free ops
        branch(8'h30, 8'h90, 8'h55, 1'b0, 2'b00, 8'h32);
        branch(8'h30, 8'h90, 8'h55, 1'b1, 2'b10, 8'h55);
        single(8'h40, 8'hA0, 1'b1, 2'b11, 1'b0);
        tick();
        chk("T4 JR pc", bus.pc, alu_res);
        single(8'h44, 8'hB0, 1'b1, 2'b01, 1'b0);
        tick();
        chk("T4 BACK pc", bus.pc, 8'h43);
        single(8'h48, 8'hD7, 1'b1, 2'b00, 1'b0);
        tick();
        single(8'h4A, 8'h7F, 1'b1, 2'b00, 1'b1);
        tick();

        // T5: timeout after 15 silent cycles, sticky until clr
        mem[8'h50] = 8'h00;
        ready_mode = 0;
        bus.mem_ready = 1'b0;
        start_at(8'h50);
        repeat (14) tick();
        chk("T5 c15 fault", bus.fault, 0);
        chk("T5 c15 mem_rd", bus.mem_rd, 1);
        tick();
        chk("T5 fault", bus.fault, 1);
        chk("T5 fault mem_rd", bus.mem_rd, 0);
        ready_mode = 1;
        repeat (5) tick();
        chk("T5 fault held", bus.fault, 1);
        chk("T5 fault pc_en", bus.pc_en, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_quiet("T5 clr");
        // ready arriving in the 15th cycle wins
        ready_mode = 0;
        bus.mem_ready = 1'b0;
        start_at(8'h50);
        repeat (13) tick();
        ready_mode = 1;
        tick();
        chk("T5b c15 mem_rd", bus.mem_rd, 1);
        tick();
        chk("T5b fault", bus.fault, 0);
        chk("T5b decode pc_en", bus.pc_en, 1);
        chk("T5b decode ir", bus.ir, 8'h00);
        tick();

        // T6: HLT
        mem[8'h60] = 8'hF0;
        start_at(8'h60);
        tick();
        chk("T6 dec pc_en", bus.pc_en, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("T6 halted", bus.halted, 1);
            chk("T6 pc_en", bus.pc_en, 0);
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("T6 clr halted", bus.halted, 0);

        // T6b: clr during FETCH2 of a second jump
        mem[8'h70] = 8'h80;
        mem[8'h71] = 8'h99;
        mem[8'h99] = 8'h80;
        mem[8'h9A] = 8'hAA;
        bus.pc = 8'h70;
        bus.mem_rdata = mem[8'h70];
        bus.run = 1'b1;
        repeat (7) tick();
        chk("T6b fetch2 addr", bus.mem_addr, 8'h9A);
        chk("T6b fetch2 target", bus.jump_target, 8'h99);
        clr = 1'b1;
        tick();
        chk_quiet("T6b clr");
        clr = 1'b0;
        bus.run = 1'b0;
        tick();

        // Random programs against an instruction-level interpreter
        for (int r = 0; r < 4; r++) begin
            clr = 1'b1;
            bus.run = 1'b0;
            tick();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            p       = 8'($urandom);
            z       = 1'($urandom);
            alu_res = 8'($urandom);
            exp_q.delete();
            exp_alu  = 0;
            exp_halt = 1'b0;
            bus.pc        = p;
            bus.mem_rdata = mem[p];
            while (exp_q.size() < 120 && !exp_halt) begin
                op = mem[p];
                exp_q.push_back(p);
                case (op[7:4])
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        exp_alu++;
                        p = p + 8'd1;
                    end
                    4'h8: begin
                        exp_q.push_back(p + 8'd1);
                        p = mem[p + 8'd1];
                    end
                    4'h9: begin
                        exp_q.push_back(p + 8'd1);
                        p = z ? mem[p + 8'd1] : p + 8'd2;
                    end
                    4'hA: p = alu_res;
                    4'hB: p = p - 8'd1;
                    4'hF: exp_halt = 1'b1;
                    default: p = p + 8'd1;
                endcase
            end
            fetch_q.delete();
            alu_go_seen  = 0;
            ready_mode   = 2;
            streak       = 0;
            bus.alu_zero = z;
            clr          = 1'b0;
            bus.run      = 1'b1;
            cycles       = 0;
            while (fetch_q.size() < exp_q.size() && cycles < 5000) begin
                tick();
                cycles++;
            end
            chk("rand budget", {31'd0, fetch_q.size() >= exp_q.size()}, 1);
            tick();
            for (int i = 0; i < exp_q.size() && i < fetch_q.size(); i++) begin
                chk("rand fetch addr", fetch_q[i], exp_q[i]);
                if (fetch_q[i] !== exp_q[i]) break;
            end
            chk("rand alu_go count", alu_go_seen, exp_alu);
            chk("rand fault", bus.fault, 0);
            if (exp_halt) begin
                tick();
                chk("rand halted", bus.halted, 1);
            end
            ready_mode = 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
